// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM state encoding,
// instruction field positions and the one-hot strobe layout.
package alu_seq_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;

  // Instruction field positions
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;
  localparam int IMM_HI = 8;
  localparam int IMM_LO = 0;
  localparam int IMM_W  = IMM_HI - IMM_LO + 1;

  // Opcodes; everything above OP_LDI is illegal
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_PASS = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_SHR  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPND = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // Bit positions inside the internal strobe vector
  localparam int STB_PASS = 0;
  localparam int STB_ADD  = 1;
  localparam int STB_SUB  = 2;
  localparam int STB_SHR  = 3;
  localparam int STB_SHL  = 4;
  localparam int STB_AND  = 5;
  localparam int STB_OR   = 6;
  localparam int STB_XOR  = 7;
  localparam int STB_NOT  = 8;
  localparam int STB_W    = 9;

  // One-hot strobe for an opcode; NOP and illegal opcodes give all zeros.
  function automatic logic [STB_W-1:0] decode_strobes(input logic [3:0] op);
    logic [STB_W-1:0] s;
    s = '0;
    case (op)
      OP_PASS: s[STB_PASS] = 1'b1;
      OP_LDI:  s[STB_PASS] = 1'b1;
      OP_ADD:  s[STB_ADD]  = 1'b1;
      OP_SUB:  s[STB_SUB]  = 1'b1;
      OP_SHR:  s[STB_SHR]  = 1'b1;
      OP_SHL:  s[STB_SHL]  = 1'b1;
      OP_AND:  s[STB_AND]  = 1'b1;
      OP_OR:   s[STB_OR]   = 1'b1;
      OP_XOR:  s[STB_XOR]  = 1'b1;
      OP_NOT:  s[STB_NOT]  = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seq_regfile.sv
// 8x16 architectural register file for the ALU sequencer.
// Ports: clk/rst (sync, active-high, clears all registers); two combinational
// read ports (ra1/rd1, ra2/rd2) that the sequencer registers onto its operand
// buses; one write port (we/wa/wd) committed on the clock edge; one
// combinational debug read port (dbg_addr/dbg_data).
// With R0_ZERO=1, r0 reads as zero on every port and writes to it are dropped.
module seq_regfile
  import alu_seq_pkg::*;
#(
  parameter bit R0_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we && !(R0_ZERO && (wa == '0))) regs_d[wa] = wd;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  assign rd1      = (R0_ZERO && (ra1 == '0))      ? '0 : regs_q[ra1];
  assign rd2      = (R0_ZERO && (ra2 == '0))      ? '0 : regs_q[ra2];
  assign dbg_data = (R0_ZERO && (dbg_addr == '0)) ? '0 : regs_q[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control stage in front of the 16-bit logic unit.
// Accepts one instruction per valid/ready handshake, walks it through
// IDLE -> OPND -> EXEC -> WB, drives operand buses bus1/bus2 from the register
// file, raises exactly one ALU strobe during EXEC, captures bus3 and writes it
// back in WB together with the Z/N/C flags.
// Ports: clk, rst (sync active-high); instr/instr_valid/instr_ready handshake;
// one-hot strobes passthrough..bnegate; bus1/bus2 operands out, bus3 result in;
// done (WB pulse); flag_z/n/c; err (illegal opcode); dbg_addr/dbg_data debug read.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter bit R0_ZERO        = 1'b0,
  parameter bit ILLEGAL_STICKY = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              passthrough,
  output logic              add,
  output logic              sub,
  output logic              shr,
  output logic              shl,
  output logic              band,
  output logic              bor,
  output logic              bxor,
  output logic              bnegate,
  output logic [DATA_W-1:0] bus1,
  output logic [DATA_W-1:0] bus2,
  input  logic [DATA_W-1:0] bus3,
  output logic              done,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              err,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] bus1_q, bus1_d;
  logic [DATA_W-1:0] bus2_q, bus2_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [STB_W-1:0]  stb_q, stb_d;
  logic              done_q, done_d;
  logic              z_q, z_d, n_q, n_d, c_q, c_d;
  logic              carry_q, carry_d;
  logic              err_q, err_d;

  logic [3:0]        op;
  logic              op_illegal, op_writes;
  logic [DATA_W-1:0] rd1, rd2;
  logic              rf_we;
  logic [DATA_W:0]   sum17;

  assign op         = instr_q[OPC_HI:OPC_LO];
  assign op_illegal = (op > OP_LDI);
  assign op_writes  = (op != OP_NOP) && !op_illegal;

  // Low bits of the word are only meaningful as part of imm9 for LDI.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr_q[2:0];

  seq_regfile #(.R0_ZERO(R0_ZERO)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .ra1      (instr_q[RS1_HI:RS1_LO]),
    .rd1      (rd1),
    .ra2      (instr_q[RS2_HI:RS2_LO]),
    .rd2      (rd2),
    .we       (rf_we),
    .wa       (instr_q[RD_HI:RD_LO]),
    .wd       (result_q),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // A sticky error parks the sequencer until reset.
  assign instr_ready = (state_q == ST_IDLE) && !(ILLEGAL_STICKY && err_q);

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    bus1_d   = bus1_q;
    bus2_d   = bus2_q;
    result_d = result_q;
    stb_d    = '0;
    done_d   = 1'b0;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    carry_d  = carry_q;
    err_d    = err_q;
    rf_we    = 1'b0;
    sum17    = '0;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid && instr_ready) begin
          instr_d = instr;
          state_d = ST_OPND;
        end
      end

      ST_OPND: begin
        if (op == OP_LDI) begin
          bus1_d = {{(DATA_W-IMM_W){instr_q[IMM_HI]}}, instr_q[IMM_HI:IMM_LO]};
          bus2_d = '0;
        end else begin
          bus1_d = rd1;
          bus2_d = rd2;
        end
        // Carry is derived from the same operands the ALU will see, so WB
        // never depends on bus3 for C.
        sum17 = {1'b0, bus1_d} + {1'b0, bus2_d};
        if (op == OP_ADD)      carry_d = sum17[DATA_W];
        else if (op == OP_SUB) carry_d = (bus1_d < bus2_d);
        else                   carry_d = 1'b0;
        stb_d   = decode_strobes(op);
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        // bus3 is only meaningful while a strobe is driving the ALU.
        if (|stb_q) result_d = bus3;
        if (op_illegal) err_d = 1'b1;
        done_d  = 1'b1;
        state_d = ST_WB;
      end

      ST_WB: begin
        if (op_writes) begin
          rf_we = 1'b1;
          z_d   = (result_q == '0);
          n_d   = result_q[DATA_W-1];
          if ((op == OP_ADD) || (op == OP_SUB)) c_d = carry_q;
        end
        if (!ILLEGAL_STICKY) err_d = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      bus1_q   <= '0;
      bus2_q   <= '0;
      result_q <= '0;
      stb_q    <= '0;
      done_q   <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      bus1_q   <= bus1_d;
      bus2_q   <= bus2_d;
      result_q <= result_d;
      stb_q    <= stb_d;
      done_q   <= done_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
    end
  end

  assign passthrough = stb_q[STB_PASS];
  assign add         = stb_q[STB_ADD];
  assign sub         = stb_q[STB_SUB];
  assign shr         = stb_q[STB_SHR];
  assign shl         = stb_q[STB_SHL];
  assign band        = stb_q[STB_AND];
  assign bor         = stb_q[STB_OR];
  assign bxor        = stb_q[STB_XOR];
  assign bnegate     = stb_q[STB_NOT];
  assign bus1        = bus1_q;
  assign bus2        = bus2_q;
  assign done        = done_q;
  assign flag_z      = z_q;
  assign flag_n      = n_q;
  assign flag_c      = c_q;
  assign err         = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        passthrough, add, sub, shr, shl, band, bor, bxor, bnegate;
  logic [15:0] bus1, bus2, bus3;
  logic        done, flag_z, flag_n, flag_c, err;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [8:0]  stb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.R0_ZERO(1'b1), .ILLEGAL_STICKY(1'b1)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .passthrough(passthrough), .add(add),
    .sub(sub), .shr(shr), .shl(shl), .band(band), .bor(bor), .bxor(bxor),
    .bnegate(bnegate), .bus1(bus1), .bus2(bus2), .bus3(bus3), .done(done),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  assign stb = {bnegate, bxor, bor, band, shl, shr, sub, add, passthrough};

  // Behavioural model of the downstream logic unit
  always_comb begin
    bus3 = 16'hDEAD;
    if (passthrough)  bus3 = bus1;
    else if (add)     bus3 = bus1 + bus2;
    else if (sub)     bus3 = bus1 - bus2;
    else if (shr)     bus3 = (bus2 >= 16) ? 16'h0 : (bus1 >> bus2[3:0]);
    else if (shl)     bus3 = (bus2 >= 16) ? 16'h0 : (bus1 << bus2[3:0]);
    else if (band)    bus3 = bus1 & bus2;
    else if (bor)     bus3 = bus1 | bus2;
    else if (bxor)    bus3 = bus1 ^ bus2;
    else if (bnegate) bus3 = ~bus1;
  end

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  function automatic logic [15:0] enc_ldi(input logic [2:0] rd, input logic [8:0] imm);
    return {4'hA, rd, imm};
  endfunction

  // Handshake one instruction; lat = posedges after the handshake edge until
  // done is seen (-1 if never accepted or done never came). Returns in WB.
  task automatic issue(input logic [15:0] w, output int lat);
    int t;
    lat = -1;
    t = 0;
    @(negedge clk);
    while (!instr_ready && t < 20) begin @(negedge clk); t++; end
    if (!instr_ready) return;
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  task automatic peek(input logic [2:0] a, output logic [15:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (done !== 1'b0 || stb !== 9'h0) begin errors++; $display("FAIL reset_outputs: done=%b stb=%h want 0/0", done, stb); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    do_reset();
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
    checks++; if (bus1 !== 16'h0 || bus2 !== 16'h0) begin errors++; $display("FAIL reset_bus: bus1=%h bus2=%h want 0", bus1, bus2); end
    checks++; if ({flag_z, flag_n, flag_c, err} !== 4'b0) begin errors++; $display("FAIL reset_flags: zncE=%b want 0000", {flag_z, flag_n, flag_c, err}); end
    peek(3'd5, v);
    checks++; if (v !== 16'h0) begin errors++; $display("FAIL reset_reg: r5=%h want 0000", v); end
  endtask

  // Handshake cycle, OPND, EXEC, WB: done appears 2 edges after the accept edge.
  task automatic test_ldi();
    int lat; logic [15:0] v;
    issue(enc_ldi(3'd1, 9'd5), lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ldi_latency: got %0d want 2", lat); end
    settle();
    peek(3'd1, v);
    checks++; if (v !== 16'h0005) begin errors++; $display("FAIL ldi_r1: got %h want 0005", v); end
    checks++; if ({flag_z, flag_n} !== 2'b00) begin errors++; $display("FAIL ldi_flags: zn=%b want 00", {flag_z, flag_n}); end
  endtask

  task automatic test_add();
    int lat; logic [15:0] v;
    issue(enc_ldi(3'd2, 9'h1FF), lat); settle();
    peek(3'd2, v);
    checks++; if (v !== 16'hFFFF) begin errors++; $display("FAIL ldi_signext: r2=%h want ffff", v); end
    issue(enc_r(4'h2, 3'd3, 3'd2, 3'd2), lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d want 2", lat); end
    settle();
    peek(3'd3, v);
    checks++; if (v !== 16'hFFFE) begin errors++; $display("FAIL add_r3: got %h want fffe", v); end
    checks++; if ({flag_z, flag_n, flag_c} !== 3'b011) begin errors++; $display("FAIL add_flags: znc=%b want 011", {flag_z, flag_n, flag_c}); end
  endtask

  task automatic test_sub();
    int lat; logic [15:0] v;
    issue(enc_ldi(3'd1, 9'd3), lat); settle();
    issue(enc_ldi(3'd2, 9'd3), lat); settle();
    issue(enc_r(4'h3, 3'd4, 3'd1, 3'd2), lat); settle();
    peek(3'd4, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL sub_r4: got %h want 0000", v); end
    checks++; if ({flag_z, flag_n, flag_c} !== 3'b100) begin errors++; $display("FAIL sub_eq_flags: znc=%b want 100", {flag_z, flag_n, flag_c}); end
    issue(enc_r(4'h3, 3'd5, 3'd4, 3'd1), lat); settle();
    peek(3'd5, v);
    checks++; if (v !== 16'hFFFD) begin errors++; $display("FAIL sub_r5: got %h want fffd", v); end
    checks++; if ({flag_z, flag_n, flag_c} !== 3'b011) begin errors++; $display("FAIL sub_borrow_flags: znc=%b want 011", {flag_z, flag_n, flag_c}); end
  endtask

  task automatic test_back_to_back();
    int lat, idx, since, dones, k;
    logic acc;
    logic [15:0] prog [3];
    logic [8:0]  xs   [3];
    logic [15:0] v;
    issue(enc_ldi(3'd6, 9'h0F0), lat); settle();
    issue(enc_ldi(3'd7, 9'h0CC), lat); settle();
    prog[0] = enc_r(4'h6, 3'd1, 3'd6, 3'd7); xs[0] = 9'b000100000;
    prog[1] = enc_r(4'h7, 3'd2, 3'd6, 3'd7); xs[1] = 9'b001000000;
    prog[2] = enc_r(4'h8, 3'd3, 3'd6, 3'd7); xs[2] = 9'b010000000;
    idx = 0; since = 3; dones = 0;
    for (int it = 0; it < 13; it++) begin
      @(negedge clk);
      instr_valid = (idx < 3);
      if (idx < 3) instr = prog[idx];
      acc = instr_valid && instr_ready;
      @(posedge clk); #1;
      if (acc) begin idx++; since = 0; end else since++;
      if (done) dones++;
      if (since < 3) begin
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low: got %b want 0 (instr %0d, cycle %0d)", instr_ready, idx, since); end
      end
      if (since == 1) begin
        k = idx - 1;
        checks++; if (stb !== xs[k]) begin errors++; $display("FAIL b2b_strobe: got %b want %b", stb, xs[k]); end
      end
    end
    instr_valid = 1'b0;
    checks++; if (idx !== 3) begin errors++; $display("FAIL b2b_accepts: got %0d want 3", idx); end
    checks++; if (dones !== 3) begin errors++; $display("FAIL b2b_dones: got %0d want 3", dones); end
    peek(3'd1, v);
    checks++; if (v !== 16'h00C0) begin errors++; $display("FAIL b2b_and: got %h want 00c0", v); end
    peek(3'd2, v);
    checks++; if (v !== 16'h00FC) begin errors++; $display("FAIL b2b_or: got %h want 00fc", v); end
    peek(3'd3, v);
    checks++; if (v !== 16'h003C) begin errors++; $display("FAIL b2b_xor: got %h want 003c", v); end
    checks++; if ({flag_z, flag_n, flag_c} !== 3'b001) begin errors++; $display("FAIL b2b_flags: znc=%b want 001", {flag_z, flag_n, flag_c}); end
  endtask

  task automatic test_r0();
    int lat; logic [15:0] v;
    issue(enc_ldi(3'd0, 9'd7), lat); settle();
    peek(3'd0, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL r0_zero: got %h want 0000", v); end
  endtask

  task automatic test_illegal();
    int lat; logic [15:0] v;
    issue(enc_ldi(3'd1, 9'd5), lat); settle();
    issue(enc_r(4'h0, 3'd1, 3'd0, 3'd0), lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL nop_latency: got %0d want 2", lat); end
    settle();
    peek(3'd1, v);
    checks++; if (v !== 16'h0005) begin errors++; $display("FAIL nop_nowrite: r1=%h want 0005", v); end
    checks++; if ({flag_z, flag_n, flag_c} !== 3'b001) begin errors++; $display("FAIL nop_flags: znc=%b want 001", {flag_z, flag_n, flag_c}); end
    issue(enc_r(4'hC, 3'd1, 3'd1, 3'd1), lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ill_latency: got %0d want 2", lat); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_err_wb: got %b want 1", err); end
    settle();
    peek(3'd1, v);
    checks++; if (v !== 16'h0005) begin errors++; $display("FAIL ill_nowrite: r1=%h want 0005", v); end
    checks++; if ({flag_z, flag_n, flag_c} !== 3'b001) begin errors++; $display("FAIL ill_flags: znc=%b want 001", {flag_z, flag_n, flag_c}); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      instr = enc_ldi(3'd1, 9'd9);
      instr_valid = 1'b1;
      @(posedge clk); #1;
      checks++; if (instr_ready !== 1'b0 || err !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ill_sticky: ready=%b err=%b done=%b want 0/1/0", instr_ready, err, done); end
    end
    instr_valid = 1'b0;
    peek(3'd1, v);
    checks++; if (v !== 16'h0005) begin errors++; $display("FAIL ill_blocked: r1=%h want 0005", v); end
    do_reset();
    checks++; if (err !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL ill_clear: err=%b ready=%b want 0/1", err, instr_ready); end
  endtask

  task automatic test_reset_mid();
    int lat, dones; logic [15:0] v;
    issue(enc_ldi(3'd1, 9'd4), lat); settle();
    @(negedge clk);
    instr = enc_r(4'h2, 3'd6, 3'd1, 3'd1);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (stb !== 9'b000000010) begin errors++; $display("FAIL mid_exec_strobe: got %b want 000000010", stb); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL mid_no_done: got %0d want 0", dones); end
    checks++; if (instr_ready !== 1'b1 || stb !== 9'h0) begin errors++; $display("FAIL mid_idle: ready=%b stb=%h want 1/0", instr_ready, stb); end
    peek(3'd6, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL mid_nowrite: r6=%h want 0000", v); end
  endtask

  initial begin
    rst = 1'b1;
    instr = 16'h0;
    instr_valid = 1'b0;
    dbg_addr = 3'd0;
    test_reset();
    test_ldi();
    test_add();
    test_sub();
    test_back_to_back();
    test_r0();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end

endmodule
